sl_rx_fifo_ctrl: RTL and testbench
==================================

Name: sl_rx_fifo_ctrl

Overview:
Parametrised second-generation serial-line (SL) receiver for the two-wire SL bus. Line sl1 carries ones and sl0 carries zeroes; both lines idle high. The block decodes words of run-time-selectable length with optional odd parity and classifies errors. Completed words and their error flags go into an internal receive FIFO, drained through a valid/ready interface by the bus-interface block.

Parameters:
MAX_WORD_LEN, 32, maximum data bits per word; rx_data width.
STROBE_POS, 8, clk cycles from bit start to line sample.
IDLE_MIN, 4, consecutive cycles both lines must be high before a bit start is accepted.
BIT_END, 8, consecutive both-high cycles that end a bit.
FIFO_DEPTH, 4, receive FIFO entries; power of two, 2 or more.
TIMEOUT_CYCLES, 256, inter-bit timeout; used only with SL_RX_TIMEOUT_EN.

Ports:
clk  in  1  system clock (16 MHz)
rst_n  in  1  asynchronous active-low reset
sl0_a  in  1  zeroes line, asynchronous, double-flopped internally
sl1_a  in  1  ones line, asynchronous, double-flopped internally
cfg_enable  in  1  receiver enable
cfg_word_len  in  6  data bits per word, legal range 1..MAX_WORD_LEN
cfg_parity_en  in  1  expect and check a parity bit after the data bits
rx_data  out  MAX_WORD_LEN  head-of-FIFO data, LSB = first received bit
rx_err  out  3  head flags: [0] length error, [1] parity error, [2] level error
rx_valid  out  1  FIFO not empty
rx_ready  in  1  pop on rx_valid && rx_ready
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
busy  out  1  word reception in progress
overflow  out  1  sticky; set when a word is dropped because the FIFO is full
clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, synchroniser flops 1.
- The FSM runs on synchronised lines s0 and s1.
- States: IDLE, SAMPLE, WAIT_END, FINISH.
- IDLE:
  - Counts both-high cycles, saturating.
  - Bit start: s0 or s1 low while the count is at least IDLE_MIN. Go to SAMPLE, cycle_cnt=1.
  - On the first bit of a word: latch cfg_word_len and cfg_parity_en, set busy. Config changes mid-word have no effect on that word.
- SAMPLE: when cycle_cnt==STROBE_POS, decode:
  - s1=0, s0=1: one bit.
  - s1=1, s0=0: zero bit.
  - both 0: stop. Go to FINISH.
  - both 1: level error. Set lev flag and go to WAIT_END.
  - Data bits shift in LSB first. bit_cnt saturates at MAX_WORD_LEN+2.
- WAIT_END: after BIT_END consecutive both-high cycles, return to IDLE.
  - If lev flag is set, go to FINISH instead.
- FINISH, evaluated in one cycle:
  - len = bit_cnt != word_len + parity_en.
  - par = parity_en && !len && even number of ones across data+parity.
  - Push {data, flags} into the FIFO. On any error, data is forced to 0. Parity bit is never stored.
  - Clear counters and busy; go to WAIT_END with lev cleared.
- Latency: rx_valid rises 2 clk after the stop-bit strobe cycle when the FIFO was empty.
- FIFO rules:
  - Push while full: word dropped, overflow set.
  - Simultaneous push and pop while full: both succeed, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
  - If clr_overflow and a new overflow occur in the same cycle, overflow stays 1.
- cfg_enable low: the in-progress word is aborted silently (no push), FSM goes to IDLE, busy=0. FIFO contents and pops are unaffected.
- Asynchronous reset mid-word: everything is cleared immediately; a partial word is never pushed.

Optional Feature:
SL_RX_TIMEOUT_EN:
- Defined: an inter-bit counter runs while busy in IDLE and WAIT_END. Reaching TIMEOUT_CYCLES pushes the word with the length flag set and returns to IDLE.
- Undefined: no timeout; a word stays pending until a stop bit, abort or reset.

Decomposition:
- Package sl_pkg holds:
  - FSM state encoding.
  - Error-bit index constants ERR_LEN=0, ERR_PAR=1, ERR_LEV=2.
  - Line-symbol decode constants.
- Sub-module sl_sync_fifo: generic synchronous FIFO parametrised by width and depth, providing level, full and empty. It stores {rx_err, rx_data}.

Test Plan:
- word_len=8, parity on, send 0xA5 + parity bit 1 + stop -> rx_data=0xA5, rx_err=000, rx_valid 2 clk after stop strobe.
- Same setup, parity bit 0 -> rx_data=0, rx_err=010.
- word_len=8, send 7 bits + stop -> rx_err=001, data=0.
- Both lines released at strobe of bit 3 -> after BIT_END, entry with rx_err=100; next 0x3C word received cleanly.
- FIFO_DEPTH=4, rx_ready=0, send 5 words -> fifo_level=4, overflow=1, first four words intact. clr_overflow -> overflow=0. Drain order is preserved.
- Drop cfg_enable at bit 4 of a word -> no push, busy=0. Re-enable, send 0xFF with parity off, word_len=8 -> rx_data=0xFF.

Source files
------------

// File: rtl/sl_pkg.sv
// Shared constants for the SL receiver: FSM encoding, error-flag bit indices
// and line-symbol decode values.
package sl_pkg;

    // Receiver FSM encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SAMPLE   = 2'd1;
    localparam logic [1:0] ST_WAIT_END = 2'd2;
    localparam logic [1:0] ST_FINISH   = 2'd3;

    // Bit positions inside rx_err
    localparam int unsigned ERR_LEN = 0;
    localparam int unsigned ERR_PAR = 1;
    localparam int unsigned ERR_LEV = 2;
    localparam int unsigned ERR_W   = 3;

    // Line symbols as {s1, s0}; the active line is pulled low
    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_ZERO = 2'b10;
    localparam logic [1:0] SYM_STOP = 2'b00;
    localparam logic [1:0] SYM_IDLE = 2'b11;

endpackage

// File: rtl/sl_sync_fifo.sv
// Generic single-clock FIFO with occupancy, full and empty. A write while full
// is accepted only when a read happens in the same cycle. Head data reads as
// zero while empty.
module sl_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_wr, do_rd;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_wr && !do_rd)      cnt_q <= cnt_q + 1'b1;
            else if (do_rd && !do_wr) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage array, no reset needed since empty gates the head
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/sl_rx_fifo_ctrl.sv
// SL bus receiver: synchronises the two line inputs, decodes bits into words
// of configurable length with optional odd parity, and queues {err, data}
// into a receive FIFO. Optional inter-bit timeout: define SL_RX_TIMEOUT_EN.
module sl_rx_fifo_ctrl
    import sl_pkg::*;
#(
    parameter int unsigned MAX_WORD_LEN   = 32,
    parameter int unsigned STROBE_POS     = 8,
    parameter int unsigned IDLE_MIN       = 4,
    parameter int unsigned BIT_END        = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sl0_a,
    input  logic                          sl1_a,
    input  logic                          cfg_enable,
    input  logic [5:0]                    cfg_word_len,
    input  logic                          cfg_parity_en,
    output logic [MAX_WORD_LEN-1:0]       rx_data,
    output logic [2:0]                    rx_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam int unsigned BIT_W = $clog2(MAX_WORD_LEN + 3);
    localparam int unsigned CYC_W = $clog2(STROBE_POS + 1);
    localparam int unsigned IDL_W = $clog2(IDLE_MIN + 1);
    localparam int unsigned END_W = $clog2(BIT_END + 1);
    localparam int unsigned FW    = ERR_W + MAX_WORD_LEN;

    logic s0_m, s0, s1_m, s1, line_idle;
    logic [1:0]              state_q, state_d;
    logic [IDL_W-1:0]        idle_q, idle_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [END_W-1:0]        end_q, end_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [MAX_WORD_LEN-1:0] data_q, data_d;
    logic                    ones_q, ones_d, lev_q, lev_d, busy_q, busy_d;
    logic [5:0]              wlen_q, wlen_d;
    logic                    pen_q, pen_d;
    logic                    len_err, par_err;
    logic                    push, pop, fifo_full, fifo_empty, ovf_q;
    logic [ERR_W-1:0]        push_err;
    logic [MAX_WORD_LEN-1:0] push_data;
    logic [FW-1:0]           head;
`ifdef SL_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_q, to_d;
`endif

    // Two-flop synchronisers, idle-high reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_m <= 1'b1; s0 <= 1'b1; s1_m <= 1'b1; s1 <= 1'b1;
        end else begin
            s0_m <= sl0_a; s0 <= s0_m; s1_m <= sl1_a; s1 <= s1_m;
        end
    end

    assign line_idle = ({s1, s0} == SYM_IDLE);

    // A level error outranks the length/parity checks of a truncated word
    assign len_err = !lev_q && (32'(bit_q) != 32'(wlen_q) + 32'(pen_q));
    assign par_err = pen_q && !lev_q && !len_err && !ones_q;

    // Next-state logic for the bit decoder FSM
    always_comb begin
        state_d = state_q; idle_d = idle_q; cyc_d = cyc_q; end_d = end_q;
        bit_d = bit_q; data_d = data_q; ones_d = ones_q; lev_d = lev_q;
        busy_d = busy_q; wlen_d = wlen_q; pen_d = pen_q;
        push = 1'b0; push_err = '0; push_data = '0;
`ifdef SL_RX_TIMEOUT_EN
        to_d = to_q;
`endif
        if (!cfg_enable) begin
            // Silent abort: nothing is pushed
            state_d = ST_IDLE; idle_d = '0; cyc_d = '0; end_d = '0;
            bit_d = '0; data_d = '0; ones_d = 1'b0; lev_d = 1'b0; busy_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (line_idle) begin
                        if (idle_q != IDL_W'(IDLE_MIN)) idle_d = idle_q + 1'b1;
                    end else if (idle_q == IDL_W'(IDLE_MIN)) begin
                        state_d = ST_SAMPLE;
                        cyc_d   = CYC_W'(1);
                        idle_d  = '0;
                        if (!busy_q) begin
                            busy_d = 1'b1; wlen_d = cfg_word_len; pen_d = cfg_parity_en;
                            bit_d = '0; data_d = '0; ones_d = 1'b0; lev_d = 1'b0;
                        end
                    end else begin
                        idle_d = '0;
                    end
                end
                ST_SAMPLE: begin
                    if (cyc_q == CYC_W'(STROBE_POS)) begin
                        cyc_d   = '0;
                        end_d   = '0;
                        state_d = ST_WAIT_END;
                        case ({s1, s0})
                            SYM_ONE, SYM_ZERO: begin
                                // Only data bits are stored; the parity bit just feeds ones
                                if (s0 && (32'(bit_q) < 32'(wlen_q)))
                                    data_d = data_q | (MAX_WORD_LEN'(1) << bit_q);
                                if (s0) ones_d = !ones_q;
                                if (bit_q != BIT_W'(MAX_WORD_LEN + 2)) bit_d = bit_q + 1'b1;
                            end
                            SYM_STOP: state_d = ST_FINISH;
                            default:  lev_d = 1'b1;
                        endcase
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                ST_WAIT_END: begin
                    if (!line_idle) begin
                        end_d = '0;
                    end else if (end_q == END_W'(BIT_END - 1)) begin
                        end_d   = '0;
                        idle_d  = '0;
                        state_d = lev_q ? ST_FINISH : ST_IDLE;
                    end else begin
                        end_d = end_q + 1'b1;
                    end
                end
                ST_FINISH: begin
                    push = 1'b1;
                    push_err[ERR_LEN] = len_err;
                    push_err[ERR_PAR] = par_err;
                    push_err[ERR_LEV] = lev_q;
                    push_data = (len_err || par_err || lev_q) ? '0 : data_q;
                    bit_d = '0; data_d = '0; ones_d = 1'b0; lev_d = 1'b0;
                    busy_d = 1'b0; end_d = '0;
                    state_d = ST_WAIT_END;
                end
                default: state_d = ST_IDLE;
            endcase
`ifdef SL_RX_TIMEOUT_EN
            if (busy_q && (state_q == ST_IDLE || state_q == ST_WAIT_END)) begin
                if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    push = 1'b1; push_err = '0; push_err[ERR_LEN] = 1'b1; push_data = '0;
                    state_d = ST_IDLE; busy_d = 1'b0; idle_d = '0; end_d = '0;
                    bit_d = '0; data_d = '0; ones_d = 1'b0; lev_d = 1'b0; to_d = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end else begin
                to_d = '0;
            end
`endif
        end
    end

    // FSM and word-assembly state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE; idle_q <= '0; cyc_q <= '0; end_q <= '0;
            bit_q <= '0; data_q <= '0; ones_q <= 1'b0; lev_q <= 1'b0;
            busy_q <= 1'b0; wlen_q <= '0; pen_q <= 1'b0;
        end else begin
            state_q <= state_d; idle_q <= idle_d; cyc_q <= cyc_d; end_q <= end_d;
            bit_q <= bit_d; data_q <= data_d; ones_q <= ones_d; lev_q <= lev_d;
            busy_q <= busy_d; wlen_q <= wlen_d; pen_q <= pen_d;
        end
    end

`ifdef SL_RX_TIMEOUT_EN
    // Inter-bit timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_q <= '0;
        else        to_q <= to_d;
    end
`endif

    assign pop = rx_valid && rx_ready;

    // Sticky overflow; a new drop beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= (ovf_q && !clr_overflow) || (push && fifo_full && !pop);
    end

    sl_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({push_err, push_data}),
        .rd_en   (pop),
        .rd_data (head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rx_data  = head[MAX_WORD_LEN-1:0];
    assign rx_err   = head[FW-1:MAX_WORD_LEN];
    assign rx_valid = !fifo_empty;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_sl_rx_fifo_ctrl.sv
// Directed bench for sl_rx_fifo_ctrl with hand-computed expectations.
module tb_sl_rx_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sl0_a = 1'b1, sl1_a = 1'b1;
    logic        cfg_enable = 1'b0, cfg_parity_en = 1'b0;
    logic [5:0]  cfg_word_len = 6'd8;
    logic        rx_ready = 1'b0, clr_overflow = 1'b0;
    logic [31:0] rx_data;
    logic [2:0]  rx_err;
    logic        rx_valid, busy, overflow;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    sl_rx_fifo_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sl0_a         (sl0_a),
        .sl1_a         (sl1_a),
        .cfg_enable    (cfg_enable),
        .cfg_word_len  (cfg_word_len),
        .cfg_parity_en (cfg_parity_en),
        .rx_data       (rx_data),
        .rx_err        (rx_err),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .fifo_level    (fifo_level),
        .busy          (busy),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sl1_a = !b;
        sl0_a = b;
        repeat (12) tick();
        sl1_a = 1'b1;
        sl0_a = 1'b1;
        repeat (24) tick();
    endtask

    // mode 1: check rx_valid edge timing; mode 2: pop in the push cycle
    task automatic send_stop(input int mode, input string tag);
        sl1_a = 1'b0;
        sl0_a = 1'b0;
        repeat (11) tick();
        if (mode == 1) check({tag, "_lat_early"}, 64'(rx_valid), 64'd0);
        if (mode == 2) rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        if (mode == 1) check({tag, "_lat_2clk"}, 64'(rx_valid), 64'd1);
        sl1_a = 1'b1;
        sl0_a = 1'b1;
        repeat (24) tick();
    endtask

    task automatic send_word(input logic [39:0] bits, input int n, input int mode,
                             input string tag);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
        send_stop(mode, tag);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] d, input logic [2:0] e);
        check({tag, "_data"}, 64'(rx_data), 64'(d));
        check({tag, "_err"}, 64'(rx_err), 64'(e));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [39:0] w;

        // Reset state
        repeat (3) tick();
        check("rst_valid", 64'(rx_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_data", 64'(rx_data), 64'd0);
        check("rst_err", 64'(rx_err), 64'd0);
        rst_n = 1'b1;
        cfg_enable = 1'b1;
        repeat (10) tick();

        // 0xA5 with correct odd parity (four ones + parity 1)
        cfg_word_len = 6'd8;
        cfg_parity_en = 1'b1;
        w = {31'd0, 1'b1, 8'hA5};
        for (int i = 0; i < 9; i++) send_bit(w[i]);
        check("a5_busy", 64'(busy), 64'd1);
        send_stop(1, "a5");
        check_head("a5", 32'hA5, 3'b000);
        check("a5_level", 64'(fifo_level), 64'd1);
        pop_one();
        check("a5_pop_valid", 64'(rx_valid), 64'd0);

        // Same word with wrong parity
        w = {31'd0, 1'b0, 8'hA5};
        send_word(w, 9, 1, "par");
        check_head("par", 32'h0, 3'b010);
        pop_one();

        // Seven bits where eight are expected
        cfg_parity_en = 1'b0;
        w = 40'h5A;
        send_word(w, 7, 1, "len");
        check_head("len", 32'h0, 3'b001);
        pop_one();

        // Level error: line released before the strobe of bit 3
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        sl1_a = 1'b0;
        repeat (3) tick();
        sl1_a = 1'b1;
        repeat (40) tick();
        check_head("lev", 32'h0, 3'b100);
        check("lev_busy", 64'(busy), 64'd0);
        pop_one();
        w = 40'h3C;
        send_word(w, 8, 1, "3c");
        check_head("3c", 32'h3C, 3'b000);
        pop_one();

        // Overflow with a depth-4 FIFO
        w = 40'h11; send_word(w, 8, 1, "f1");
        w = 40'h22; send_word(w, 8, 0, "f2");
        w = 40'h33; send_word(w, 8, 0, "f3");
        w = 40'h44; send_word(w, 8, 0, "f4");
        w = 40'h55; send_word(w, 8, 0, "f5");
        check("ovf_level", 64'(fifo_level), 64'd4);
        check("ovf_set", 64'(overflow), 64'd1);
        check_head("ovf_head", 32'h11, 3'b000);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_clr", 64'(overflow), 64'd0);
        // Push and pop together while full: no drop, no overflow
        w = 40'h66; send_word(w, 8, 2, "f6");
        check("full_pp_level", 64'(fifo_level), 64'd4);
        check("full_pp_ovf", 64'(overflow), 64'd0);
        check_head("drain0", 32'h22, 3'b000); pop_one();
        check_head("drain1", 32'h33, 3'b000); pop_one();
        check_head("drain2", 32'h44, 3'b000); pop_one();
        check_head("drain3", 32'h66, 3'b000); pop_one();
        check("drain_level", 64'(fifo_level), 64'd0);

        // Abort mid-word by dropping the enable
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("abort_busy_before", 64'(busy), 64'd1);
        cfg_enable = 1'b0;
        repeat (3) tick();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_level", 64'(fifo_level), 64'd0);
        cfg_enable = 1'b1;
        repeat (10) tick();
        w = 40'hFF;
        send_word(w, 8, 1, "ff");
        check_head("ff", 32'hFF, 3'b000);
        check("ff_level", 64'(fifo_level), 64'd1);
        pop_one();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
